// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Instruction front end for the 8-bit ALU datapath. It takes 16-bit
// instruction words over a valid/ready handshake and reads operands from a
// 4x8 register file. It drives the ALU inputs for ALU_LAT cycles, samples the
// ALU result, writes it back, and pulses done.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst          - synchronous, active-high reset
//   instr_valid  - instruction word present on instr
//   instr        - [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm
//   instr_ready  - sequencer can accept an instruction (IDLE)
//   alu_a/alu_b  - ALU operands, zero outside EXEC
//   alu_op_sel   - ALU operation select, 4'hF (idle code) outside EXEC
//   alu_result   - combinational ALU output, sampled at the end of EXEC
//   done         - one-cycle retirement pulse (the WB cycle)
//   result       - value retired with done, held until the next done
//   err          - high with done when the opcode was illegal
//   dbg_addr     - debug register-file read address
//   dbg_data     - combinational read of regs[dbg_addr]

module alu_op_sequencer #(
    parameter int ALU_LAT = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op_sel,
    input  logic [7:0]  alu_result,
    output logic        done,
    output logic [7:0]  result,
    output logic        err,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_IDLE = 4'hF;

    // Counter counts down to zero, so EXEC lasts exactly ALU_LAT cycles.
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    logic [1:0] state;
    logic [3:0] op_q;
    logic [1:0] rd_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] res_q;
    logic [3:0] cnt_q;
    logic       illegal_q;
    logic [7:0] regs [4];

    // Instruction field decode
    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [7:0] in_imm;
    logic       in_is_alu;
    logic       in_is_illegal;
    logic       accept;

    assign in_op  = instr[15:12];
    assign in_rd  = instr[11:10];
    assign in_rs1 = instr[9:8];
    assign in_rs2 = instr[7:6];
    assign in_imm = instr[7:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves in_is_alu unassigned (no latch).
        in_is_alu = 1'b0;
        case (in_op)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6: in_is_alu = 1'b1;
            default:                            in_is_alu = 1'b0;
        endcase
    end

    assign in_is_illegal = !in_is_alu && (in_op != OP_LDI);
    assign accept        = instr_valid && instr_ready;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            // NOTE: the register file is architecturally zero after reset, so it is cleared here like any flop.
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= in_op;
                        rd_q      <= in_rd;
                        a_q       <= regs[in_rs1];
                        b_q       <= (in_op == OP_NOT) ? 8'h00 : regs[in_rs2];
                        illegal_q <= in_is_illegal;
                        cnt_q     <= LAT_LOAD;
                        if (in_is_alu) begin
                            state <= S_EXEC;
                        end else begin
                            // LDI and illegal opcodes skip the ALU; the
                            // retired value is known at accept time.
                            res_q <= in_is_illegal ? 8'h00 : in_imm;
                            state <= S_WB;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_q <= alu_result;
                        state <= S_WB;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WB: begin
                    if (!illegal_q) begin
                        regs[rd_q] <= res_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state == S_IDLE);
    assign alu_a       = (state == S_EXEC) ? a_q  : 8'h00;
    assign alu_b       = (state == S_EXEC) ? b_q  : 8'h00;
    assign alu_op_sel  = (state == S_EXEC) ? op_q : OP_IDLE;

    // The write in WB is cancelled by a reset sampled at its closing edge;
    // done is masked by rst so it never reports a retirement that is dropped.
    assign done     = (state == S_WB) && !rst;
    assign err      = done && illegal_q;
    assign result   = res_q;
    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Two instances: ALU_LAT=1 (functional sequence)
// and ALU_LAT=3 (latency, backpressure, reset mid-EXEC). A behavioural ALU
// drives alu_result from each instance's own ALU outputs.

module tb_alu_op_sequencer;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic [1:0]  dbg_addr;
    logic        sel;          // 0: observe/drive lat1 instance, 1: lat3 instance

    logic        ready1, done1, err1, ready3, done3, err3;
    logic [7:0]  a1, b1, res1, ar1, dbg1, a3, b3, res3, ar3, dbg3;
    logic [3:0]  op1, op3;
    logic        valid1, valid3;

    logic        o_ready, o_done, o_err;
    logic [7:0]  o_a, o_b, o_result, o_dbg;
    logic [3:0]  o_op_sel;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   hs_cycle = 0;
    exp_t sb[$];

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            4'h6:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    assign ar1    = alu_model(op1, a1, b1);
    assign ar3    = alu_model(op3, a3, b3);
    assign valid1 = instr_valid && !sel;
    assign valid3 = instr_valid && sel;

    assign o_ready  = sel ? ready3 : ready1;
    assign o_done   = sel ? done3  : done1;
    assign o_err    = sel ? err3   : err1;
    assign o_a      = sel ? a3     : a1;
    assign o_b      = sel ? b3     : b1;
    assign o_op_sel = sel ? op3    : op1;
    assign o_result = sel ? res3   : res1;
    assign o_dbg    = sel ? dbg3   : dbg1;

    alu_op_sequencer #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(valid1), .instr(instr),
        .instr_ready(ready1), .alu_a(a1), .alu_b(b1), .alu_op_sel(op1),
        .alu_result(ar1), .done(done1), .result(res1), .err(err1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    alu_op_sequencer #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(valid3), .instr(instr),
        .instr_ready(ready3), .alu_a(a3), .alu_b(b3), .alu_op_sel(op3),
        .alu_result(ar3), .done(done3), .result(res3), .err(err3),
        .dbg_addr(dbg_addr), .dbg_data(dbg3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dbg(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        check(tag, o_dbg, exp);
    endtask

    // Drives one instruction, waits for the handshake, records the expected
    // retirement, and returns at the first negedge after the accept edge.
    task automatic issue(input logic [15:0] w, input logic exp_done, input logic [7:0] exp_res, input logic exp_err);
        int n;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", o_ready, 1'b1);
        hs_cycle = cycle;
        if (exp_done) sb.push_back('{res: exp_res, err: exp_err});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_compare(input int exp_lat);
        exp_t e;
        check("sb_not_empty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", o_result, e.res);
            check("err", o_err, e.err);
            check("latency", cycle - hs_cycle, exp_lat);
        end
    endtask

    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", o_done, 1'b1);
        pop_compare(exp_lat);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 2'd0;
        sel         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", o_ready, 1'b1);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_result", o_result, 8'h00);
        check("rst_op_sel", o_op_sel, 4'hF);
        check("rst_alu_a", o_a, 8'h00);
        for (int i = 0; i < 4; i++) check_dbg(2'(i), 8'h00, "rst_dbg");

        // LDI r1<-F0, LDI r2<-3C: done one cycle after accept
        issue(16'h74F0, 1'b1, 8'hF0, 1'b0);
        wait_done(1);
        issue(16'h783C, 1'b1, 8'h3C, 1'b0);
        wait_done(1);

        // AND r3<-r1,r2
        issue(16'h3D80, 1'b1, 8'h30, 1'b0);
        check("and_exec_op", o_op_sel, 4'h3);
        check("and_exec_a", o_a, 8'hF0);
        check("and_exec_b", o_b, 8'h3C);
        wait_done(2);
        @(negedge clk);
        check("result_hold", o_result, 8'h30);
        check_dbg(2'd3, 8'h30, "and_dbg_r3");

        // NOT r0<-r1
        issue(16'h6100, 1'b1, 8'h0F, 1'b0);
        check("not_exec_op", o_op_sel, 4'h6);
        check("not_exec_b", o_b, 8'h00);
        wait_done(2);

        // XOR r2<-r0,r1
        issue(16'h5840, 1'b1, 8'hFF, 1'b0);
        wait_done(2);

        // Illegal 0x9, rd=r1: err with done one cycle after accept, r1 kept
        issue(16'h9400, 1'b1, 8'h00, 1'b1);
        wait_done(1);
        @(negedge clk);
        check_dbg(2'd1, 8'hF0, "illegal_r1_kept");

        // SUB r0<-r3,r1 wraps: 0x30-0xF0 = 0x40; ADD r1<-r2,r1 wraps: 0xFF+0xF0 = 0xEF
        issue(16'h1340, 1'b1, 8'h40, 1'b0);
        wait_done(2);
        issue(16'h0640, 1'b1, 8'hEF, 1'b0);
        wait_done(2);

        // Illegal 0x2, rd=r0
        issue(16'h2000, 1'b1, 8'h00, 1'b1);
        wait_done(1);
        @(negedge clk);
        check_dbg(2'd0, 8'h40, "illegal2_r0_kept");
        check_dbg(2'd1, 8'hEF, "add_dbg_r1");
        check_dbg(2'd2, 8'hFF, "xor_dbg_r2");

        // ALU_LAT=3 instance
        sel = 1'b1;
        issue(16'h7405, 1'b1, 8'h05, 1'b0);
        wait_done(1);

        // ADD r2<-r1,r1 with SUB r3<-r2,r1 held valid behind it
        @(negedge clk);
        instr       = 16'h0940;
        instr_valid = 1'b1;
        check("bp_first_ready", o_ready, 1'b1);
        hs_cycle = cycle;
        sb.push_back('{res: 8'h0A, err: 1'b0});
        @(posedge clk);
        #1 instr = 16'h1E40;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("bp_ready_low", o_ready, 1'b0);
            check("bp_done_timing", o_done, (i == 4));
        end
        pop_compare(4);
        @(negedge clk);
        check("bp_second_accept", o_ready, 1'b1);
        hs_cycle = cycle;
        sb.push_back('{res: 8'h05, err: 1'b0});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        wait_done(4);
        @(negedge clk);
        check_dbg(2'd3, 8'h05, "sub_dbg_r3");

        // Reset in the 2nd EXEC cycle of OR r1<-r1,r2
        issue(16'h4580, 1'b0, 8'h00, 1'b0);
        check("mid_exec_op1", o_op_sel, 4'h4);
        @(negedge clk);
        check("mid_exec_op2", o_op_sel, 4'h4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_done", o_done, 1'b0);
        end
        check("post_rst_ready", o_ready, 1'b1);
        check("post_rst_op_sel", o_op_sel, 4'hF);
        check("post_rst_result", o_result, 8'h00);
        check("post_rst_sb_empty", sb.size(), 0);
        for (int i = 0; i < 4; i++) check_dbg(2'(i), 8'h00, "post_rst_dbg");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
